// File: rtl/mcs4_phase_gen.sv
// mcs4_phase_gen: programmable two-phase non-overlapping clock generator for
// MCS-4 style models. It produces PHI1/PHI2 from a single system clock,
// tracks the subcycle index within an instruction cycle, emits SYNC during
// the last subcycle, and supports run / halt / single-step control.
//
// The subcycle counter walks 0..SUB-1 and every output is a registered
// decode of the counter value being loaded, so outputs never depend
// combinationally on inputs. Halting only happens on instruction-cycle
// boundaries, which keeps downstream models from seeing truncated cycles.

module mcs4_phase_gen #(
  parameter int PHI1_HIGH    = 2,
  parameter int GAP12        = 1,
  parameter int PHI2_HIGH    = 2,
  parameter int GAP21        = 1,
  parameter int CYCLE_STATES = 8,
  localparam int SUB   = PHI1_HIGH + GAP12 + PHI2_HIGH + GAP21,
  localparam int CNT_W = (SUB > 1) ? $clog2(SUB) : 1,
  localparam int ST_W  = (CYCLE_STATES > 1) ? $clog2(CYCLE_STATES) : 1
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            run_i,
  input  logic            step_i,
  output logic            PHI1_o,
  output logic            PHI2_o,
  output logic            SYNC_o,
  output logic [ST_W-1:0] STATE_o,
  output logic            running_o,
  output logic            cycle_done_o
);

  // Counter boundaries, sized to the counter so comparisons stay width-exact.
  // PHI2 window is [P2_START, P2_END); PHI1 window is [0, P1_END).
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SUB - 1);
  localparam logic [CNT_W-1:0] P1_END   = CNT_W'(PHI1_HIGH);
  localparam logic [CNT_W-1:0] P2_START = CNT_W'(PHI1_HIGH + GAP12);
  localparam logic [CNT_W-1:0] P2_END   = CNT_W'(PHI1_HIGH + GAP12 + PHI2_HIGH);
  localparam logic [ST_W-1:0]  ST_LAST  = ST_W'(CYCLE_STATES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STEP = 2'd2
  } fsm_t;

  fsm_t             r_fsm;
  logic [CNT_W-1:0] r_cnt;
  logic [ST_W-1:0]  r_state;
  logic             r_phi1;
  logic             r_phi2;
  logic             r_sync;
  logic             r_running;
  logic             r_done;

  logic             w_cntLast;
  logic             w_stLast;
  logic             w_cycleEnd;
  logic [CNT_W-1:0] w_cntNext;
  logic [ST_W-1:0]  w_stNext;

  // PHI1 is high for the first PHI1_HIGH counts of a subcycle.
  function automatic logic phi1Of(input logic [CNT_W-1:0] c);
    return (c < P1_END);
  endfunction

  // PHI2 is high after the PHI1 window plus the first gap, for PHI2_HIGH counts.
  // The gaps on both sides guarantee the two windows never overlap.
  function automatic logic phi2Of(input logic [CNT_W-1:0] c);
    return (c >= P2_START) && (c < P2_END);
  endfunction

  // Next counter / subcycle index while active. At the end of an instruction
  // cycle both naturally wrap to zero, which is exactly the seamless restart.
  assign w_cntLast  = (r_cnt == CNT_LAST);
  assign w_stLast   = (r_state == ST_LAST);
  assign w_cycleEnd = w_cntLast && w_stLast;
  assign w_cntNext  = w_cntLast ? '0 : (r_cnt + CNT_W'(1));
  assign w_stNext   = w_cntLast ? (w_stLast ? '0 : (r_state + ST_W'(1))) : r_state;

  assign PHI1_o       = r_phi1;
  assign PHI2_o       = r_phi2;
  assign SYNC_o       = r_sync;
  assign STATE_o      = r_state;
  assign running_o    = r_running;
  assign cycle_done_o = r_done;

  // Control FSM, subcycle counter and all registered outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_fsm     <= IDLE;
      r_cnt     <= '0;
      r_state   <= '0;
      r_phi1    <= 1'b0;
      r_phi2    <= 1'b0;
      r_sync    <= 1'b0;
      r_running <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_fsm)
        IDLE: begin
          r_cnt   <= '0;
          r_state <= '0;
          r_phi2  <= 1'b0;
          r_sync  <= 1'b0;
          if (run_i || step_i) begin
            r_fsm     <= run_i ? RUN : STEP;
            r_phi1    <= phi1Of('0);
            r_running <= 1'b1;
          end else begin
            r_phi1    <= 1'b0;
            r_running <= 1'b0;
          end
        end

        RUN, STEP: begin
          if (w_cycleEnd) begin
            r_done <= 1'b1;
          end
          if (w_cycleEnd && !run_i) begin
            r_fsm     <= IDLE;
            r_cnt     <= '0;
            r_state   <= '0;
            r_phi1    <= 1'b0;
            r_phi2    <= 1'b0;
            r_sync    <= 1'b0;
            r_running <= 1'b0;
          end else begin
            if (w_cycleEnd) begin
              r_fsm <= RUN;
            end
            r_cnt     <= w_cntNext;
            r_state   <= w_stNext;
            r_phi1    <= phi1Of(w_cntNext);
            r_phi2    <= phi2Of(w_cntNext);
            r_sync    <= (w_stNext == ST_LAST);
            r_running <= 1'b1;
          end
        end

        default: begin
          r_fsm     <= IDLE;
          r_cnt     <= '0;
          r_state   <= '0;
          r_phi1    <= 1'b0;
          r_phi2    <= 1'b0;
          r_sync    <= 1'b0;
          r_running <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mcs4_phase_gen.sv
// Testbench for mcs4_phase_gen: a default instance and an alternate-parameter
// instance share stimulus. A position-in-cycle model predicts every output on
// each clock, and literal expectations at key clocks pin the model itself.

module tb_mcs4_phase_gen;

  logic clk = 1'b0;
  logic rst_n;
  logic run;
  logic step;

  logic       dPhi1, dPhi2, dSync, dRunning, dDone;
  logic [2:0] dState;
  logic       aPhi1, aPhi2, aSync, aRunning, aDone;
  logic [1:0] aState;

  int checks = 0;
  int errors = 0;

  int mPos[2];
  bit mAct[2];
  bit mDone[2];

  mcs4_phase_gen dutDflt (
    .clk_i(clk), .rst_ni(rst_n), .run_i(run), .step_i(step),
    .PHI1_o(dPhi1), .PHI2_o(dPhi2), .SYNC_o(dSync), .STATE_o(dState),
    .running_o(dRunning), .cycle_done_o(dDone)
  );

  mcs4_phase_gen #(
    .PHI1_HIGH(3), .GAP12(2), .PHI2_HIGH(1), .GAP21(1), .CYCLE_STATES(4)
  ) dutAlt (
    .clk_i(clk), .rst_ni(rst_n), .run_i(run), .step_i(step),
    .PHI1_o(aPhi1), .PHI2_o(aPhi2), .SYNC_o(aSync), .STATE_o(aState),
    .running_o(aRunning), .cycle_done_o(aDone)
  );

  initial forever #5 clk = ~clk;

  // Parameter sets of the two instances: index 0 default, 1 alternate.
  function automatic int p1Of(int i);  return (i == 0) ? 2 : 3; endfunction
  function automatic int g12Of(int i); return (i == 0) ? 1 : 2; endfunction
  function automatic int p2Of(int i);  return (i == 0) ? 2 : 1; endfunction
  function automatic int subOf(int i); return (i == 0) ? 6 : 7; endfunction
  function automatic int csOf(int i);  return (i == 0) ? 8 : 4; endfunction

  // Packed view: {PHI1, PHI2, SYNC, running, done, state[2:0]}.
  function automatic logic [7:0] dutVec(int i);
    if (i == 0) return {dPhi1, dPhi2, dSync, dRunning, dDone, dState};
    return {aPhi1, aPhi2, aSync, aRunning, aDone, 1'b0, aState};
  endfunction

  // Expected outputs from the position within the instruction cycle.
  function automatic logic [7:0] expVec(int i);
    int sub, st, p1, g12, p2;
    logic [2:0] st3;
    if (!mAct[i]) return {4'b0000, mDone[i], 3'b000};
    sub = mPos[i] % subOf(i);
    st  = mPos[i] / subOf(i);
    p1  = p1Of(i);
    g12 = g12Of(i);
    p2  = p2Of(i);
    st3 = 3'(st);
    return {(sub < p1), (sub >= p1 + g12) && (sub < p1 + g12 + p2),
            (st == csOf(i) - 1), 1'b1, mDone[i], st3};
  endfunction

  // Model: an active generator walks positions 0..L-1; at the last one it
  // signals done and either restarts (run high) or goes idle.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        mPos[i] = 0; mAct[i] = 1'b0; mDone[i] = 1'b0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        mDone[i] = 1'b0;
        if (!mAct[i]) begin
          if (run || step) begin mAct[i] = 1'b1; mPos[i] = 0; end
        end else if (mPos[i] == subOf(i) * csOf(i) - 1) begin
          mDone[i] = 1'b1;
          mPos[i]  = 0;
          if (!run) mAct[i] = 1'b0;
        end else begin
          mPos[i] = mPos[i] + 1;
        end
      end
    end
  end

  task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic s);
    run  = r;
    step = s;
  endtask

  // Every clock: both instances against the model, plus the non-overlap rule.
  always @(negedge clk) begin
    checkOutput("model_dflt", dutVec(0), expVec(0));
    checkOutput("model_alt", dutVec(1), expVec(1));
    checkOutput("overlap_dflt", {7'b0, dPhi1 & dPhi2}, 8'h00);
    checkOutput("overlap_alt", {7'b0, aPhi1 & aPhi2}, 8'h00);
  end

  initial begin
    int nPhi1, nPhi2, nSync, nDone;
    logic pPhi1, pPhi2, pSync;
    bit found;

    rst_n = 1'b0;
    applyStimulus(1'b0, 1'b0);
    repeat (3) @(negedge clk);
    checkOutput("reset_outputs", dutVec(0), 8'h00);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("idle_after_release", dutVec(0), 8'h00);

    // Free run, then drop run at clock 10 of the third default cycle.
    applyStimulus(1'b1, 1'b0);
    for (int k = 0; k <= 150; k++) begin
      @(negedge clk);
      case (k)
        0: begin
          checkOutput("first_phi1_dflt", dutVec(0), 8'b10010000);
          checkOutput("first_phi1_alt", dutVec(1), 8'b10010000);
        end
        3:   checkOutput("phi2_at_3", dutVec(0), 8'b01010000);
        21:  checkOutput("alt_sync_start", dutVec(1), 8'b10110011);
        27:  checkOutput("alt_sync_gap", dutVec(1), 8'b00110011);
        28:  checkOutput("alt_done", dutVec(1), 8'b10011000);
        41:  checkOutput("pre_sync", dutVec(0), 8'b00010110);
        42:  checkOutput("sync_start", dutVec(0), 8'b10110111);
        48:  checkOutput("done_wrap", dutVec(0), 8'b10011000);
        112: checkOutput("alt_halt_done", dutVec(1), 8'b00001000);
        143: checkOutput("halt_last_clock", dutVec(0), 8'b00110111);
        144: checkOutput("halt_done", dutVec(0), 8'b00001000);
        145: checkOutput("halted_idle", dutVec(0), 8'h00);
        default: ;
      endcase
      if (k == 106) applyStimulus(1'b0, 1'b0);
    end

    // Single step, with a second ignored step pulse mid-cycle.
    repeat (3) @(negedge clk);
    nPhi1 = 0; nPhi2 = 0; nSync = 0; nDone = 0;
    pPhi1 = dPhi1; pPhi2 = dPhi2; pSync = dSync;
    applyStimulus(1'b0, 1'b1);
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (k == 0)  applyStimulus(1'b0, 1'b0);
      if (k == 20) applyStimulus(1'b0, 1'b1);
      if (k == 21) applyStimulus(1'b0, 1'b0);
      if (dPhi1 && !pPhi1) nPhi1++;
      if (dPhi2 && !pPhi2) nPhi2++;
      if (dSync && !pSync) nSync++;
      if (dDone) nDone++;
      pPhi1 = dPhi1; pPhi2 = dPhi2; pSync = dSync;
    end
    checkOutput("step_phi1_pulses", 8'(nPhi1), 8'd8);
    checkOutput("step_phi2_pulses", 8'(nPhi2), 8'd8);
    checkOutput("step_sync_windows", 8'(nSync), 8'd1);
    checkOutput("step_done_pulses", 8'(nDone), 8'd1);
    checkOutput("step_back_idle", dutVec(0), 8'h00);

    // Asynchronous reset while PHI2 is high in subcycle 5.
    applyStimulus(1'b1, 1'b0);
    found = 1'b0;
    for (int k = 0; k < 100 && !found; k++) begin
      @(negedge clk);
      if (mAct[0] && mPos[0] == 33) found = 1'b1;
    end
    checkOutput("found_subcycle5_phi2", {7'b0, found}, 8'h01);
    checkOutput("phi2_before_reset", dutVec(0), 8'b01010101);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async_reset_dflt", dutVec(0), 8'h00);
    checkOutput("async_reset_alt", dutVec(1), 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("restart_phi1_first", dutVec(0), 8'b10010000);
    repeat (20) @(negedge clk);

    // run and step together from IDLE: continuous running.
    applyStimulus(1'b0, 1'b0);
    #2 rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("idle_before_both", dutVec(0), 8'h00);
    applyStimulus(1'b1, 1'b1);
    for (int k = 0; k <= 100; k++) begin
      @(negedge clk);
      if (k == 0) begin
        applyStimulus(1'b1, 1'b0);
        checkOutput("both_start", dutVec(0), 8'b10010000);
      end
      if (k == 48) checkOutput("both_done_continue", dutVec(0), 8'b10011000);
      if (k == 49) checkOutput("both_still_running", dutVec(0), 8'b10010000);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
